alu_shiftr_seq_32bit: RTL
=========================

ALU_SHIFTR_SEQ_32BIT -- requirements
Module: alu_shiftr_seq_32bit

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits (N is a power of two, 8..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a shift; sampled only in IDLE.
REQ-005 SHALL have port A  input  N  operand, captured when start is accepted.
REQ-006 SHALL have port S  input  6  shift amount 0..63, captured with A.
REQ-007 SHALL have port arith  input  1  1 = arithmetic right shift (sign fill); 0 = logical (zero fill); captured with A.
REQ-008 SHALL have port Z  output  N  shift result; valid while done=1; held until next accepted start.
REQ-009 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking Z valid.

Function
REQ-011 SHALL implement states IDLE, SHIFT, DONE.
REQ-012 SHALL accept start only when state=IDLE; start while busy is ignored with no effect on the operation in flight.
REQ-013 On acceptance at edge k: shift register <= A, mode <= arith, cnt <= min(S, N); next state SHIFT if cnt>0, else DONE.
REQ-014 In SHIFT each edge SHALL shift the register right by exactly one bit (fill = MSB if mode arithmetic, else 0) and decrement cnt; leaves SHIFT for DONE on the edge that shifts with cnt=1.
REQ-015 Latency: done SHALL be high exactly in the cycle following edge k+min(S,N); S=0 gives done in the cycle after edge k with Z=A.
REQ-016 S>=N SHALL yield all-zero (logical) or all-sign-bit (arithmetic) result within N shift cycles.
REQ-017 DONE SHALL last one cycle, then IDLE; start asserted during DONE is ignored.
REQ-018 Z SHALL drive the shift register directly; it changes during SHIFT and is stable in DONE and IDLE.

Reset
REQ-019 rst=1 at an edge SHALL force state IDLE, Z=0, cnt=0, busy=0, done=0, regardless of state, including mid-shift; the aborted operation produces no done.
REQ-020 rst SHALL take priority over start in the same cycle.

Configuration
REQ-021 Macro ALU_SHIFTR_ROTATE_EN defined: SHALL add input port rot (1 bit, captured with A); rot=1 selects rotate-right, fill = shifted-out LSB, cnt = S mod N; rot overrides arith.
REQ-022 Macro ALU_SHIFTR_ROTATE_EN undefined: port rot SHALL be absent and only logical/arithmetic modes exist.

Structure
REQ-023 Shared package alu_pkg SHALL hold state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), default width constant 32, and shift-count width constant 6.
REQ-024 SHALL instantiate one sub-module alu_shiftr_1bit (combinational one-position right step with fill-select input) used for every SHIFT cycle.

Verification
REQ-025 A=32'h0000_00F0, S=4, arith=0, start one cycle -> busy next cycle, done in cycle after 4 shift edges, Z=32'h0000_000F.
REQ-026 A=32'h8000_0000, S=31, arith=1 -> Z=32'hFFFF_FFFF; same with arith=0 -> Z=32'h0000_0001.
REQ-027 A=32'h1234_5678, S=0 -> done in cycle after acceptance, Z=32'h1234_5678; S=63, arith=0 -> Z=0 after 32 shift cycles.
REQ-028 Start A=32'h0000_FFFF, S=8; pulse start with A=32'h1 during SHIFT -> second request ignored, Z=32'h0000_00FF, single done pulse.
REQ-029 Assert rst after 3 of 10 shift cycles -> next cycle busy=0, done=0, Z=0; no done pulse follows; new start then completes normally.
REQ-030 With ALU_SHIFTR_ROTATE_EN: A=32'h0000_0001, S=33, rot=1 -> Z=32'h8000_0000 after 1 shift cycle.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Desc    : Shared constants for the sequential right-shift ALU: state
//           encodings, default width, shift-count width, fill-select codes.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam int c_DEFAULT_WIDTH = 32;
    localparam int c_CNT_W         = 6;

    // What enters the MSB on each one-position step
    localparam logic [1:0] c_FILL_ZERO = 2'd0;
    localparam logic [1:0] c_FILL_SIGN = 2'd1;
    localparam logic [1:0] c_FILL_LSB  = 2'd2;

    function automatic logic [c_CNT_W-1:0] clamp_count(
        input logic [c_CNT_W-1:0] s,
        input logic [c_CNT_W-1:0] lim
    );
        return (s > lim) ? lim : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shiftr_1bit.sv
`default_nettype none
// ============================================================================
// Module : alu_shiftr_1bit
// Desc   : Combinational single-position right step; the vacated MSB takes
//          zero, the sign bit or the shifted-out LSB depending on i_fill_sel.
// Rev    : 1.0  initial release
// ============================================================================
module alu_shiftr_1bit
    import alu_pkg::*;
#(
    parameter int N = c_DEFAULT_WIDTH
) (
    input  logic [N-1:0] i_data,
    input  logic [1:0]   i_fill_sel,
    output logic [N-1:0] o_data
);

    logic w_fill;

    always_comb begin
        w_fill = 1'b0;
        case (i_fill_sel)
            c_FILL_SIGN: w_fill = i_data[N-1];
            c_FILL_LSB:  w_fill = i_data[0];
            default:     w_fill = 1'b0;
        endcase
        o_data = {w_fill, i_data[N-1:1]};
    end

endmodule
`default_nettype wire

// File: rtl/alu_shiftr_seq_32bit.sv
`default_nettype none
// ============================================================================
// Module : alu_shiftr_seq_32bit
// Desc   : Bit-serial right shifter (logical/arithmetic), one position per
//          clock. Macro ALU_SHIFTR_ROTATE_EN adds port rot for rotate-right.
// Rev    : 1.0  initial release
// ============================================================================
module alu_shiftr_seq_32bit
    import alu_pkg::*;
#(
    parameter int N = c_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       A,
    input  logic [c_CNT_W-1:0] S,
    input  logic               arith,
`ifdef ALU_SHIFTR_ROTATE_EN
    input  logic               rot,
`endif
    output logic [N-1:0]       Z,
    output logic               busy,
    output logic               done
);

    localparam logic [c_CNT_W-1:0] c_N_CNT  = c_CNT_W'(N);
    localparam logic [c_CNT_W-1:0] c_N_MASK = c_CNT_W'(N - 1);

    logic [1:0]         r_state;
    logic [N-1:0]       r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mode_arith;
`ifdef ALU_SHIFTR_ROTATE_EN
    logic               r_mode_rot;
`endif
    logic               r_busy;
    logic               r_done;

    logic [c_CNT_W-1:0] w_cnt_init;
    logic [1:0]         w_fill_sel;
    logic [N-1:0]       w_step;

    // Shifts beyond the width saturate at N; rotates wrap modulo N
    always_comb begin
        w_cnt_init = clamp_count(S, c_N_CNT);
`ifdef ALU_SHIFTR_ROTATE_EN
        if (rot) begin
            w_cnt_init = S & c_N_MASK;
        end
`endif
    end

    always_comb begin
        w_fill_sel = r_mode_arith ? c_FILL_SIGN : c_FILL_ZERO;
`ifdef ALU_SHIFTR_ROTATE_EN
        if (r_mode_rot) begin
            w_fill_sel = c_FILL_LSB;
        end
`endif
    end

    alu_shiftr_1bit #(
        .N (N)
    ) u_step (
        .i_data     (r_shreg),
        .i_fill_sel (w_fill_sel),
        .o_data     (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_mode_arith <= 1'b0;
`ifdef ALU_SHIFTR_ROTATE_EN
            r_mode_rot   <= 1'b0;
`endif
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shreg      <= A;
                        r_mode_arith <= arith;
`ifdef ALU_SHIFTR_ROTATE_EN
                        r_mode_rot   <= rot;
`endif
                        r_cnt        <= w_cnt_init;
                        r_busy       <= 1'b1;
                        if (w_cnt_init != '0) begin
                            r_state <= c_ST_SHIFT;
                        end else begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    r_shreg <= w_step;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Z    = r_shreg;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
